// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared types and helpers for the programmable sequence
//                detector. Holds the run-control state encoding, the default
//                widths and the pattern-length clamp.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int c_DEF_PW = 8;   // maximum pattern length
  localparam int c_DEF_CW = 8;   // match counter / target width
  localparam int c_DEF_TW = 16;  // timeout bit counter width

  // A pattern shorter than two bits is meaningless for an overlapping
  // detector, and one longer than the history window cannot be compared.
  function automatic int clamp_len(input int len, input int pw);
    if (len < 2)
      return 2;
    else if (len > pw)
      return pw;
    else
      return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_match_core.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_match_core
//  Description : Generic overlapping match engine. Keeps the last PW-1 valid
//                bits, tracks how many have arrived (saturating at L-1) and
//                compares the newest L bits, including the bit on i_bit this
//                cycle, against the low L bits of the pattern.
//  Ports       : clk, rstn       clock / async active-low reset
//                i_clr           clear history and fill
//                i_shift         accept i_bit into the history this cycle
//                i_bit           incoming serial bit
//                i_len           effective length L (2..PW)
//                i_pattern       pattern, bit 0 = newest bit
//                o_hit           window full and newest L bits match
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_match_core #(
  parameter int PW = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_shift,
  input  logic          i_bit,
  input  logic [LW-1:0] i_len,
  input  logic [PW-1:0] i_pattern,
  output logic          o_hit
);

  logic [PW-2:0] r_hist;
  logic [LW-1:0] r_fill;
  logic [PW-1:0] w_win;
  logic [LW-1:0] w_lm1;
  logic          w_eq;

  assign w_win = {r_hist, i_bit};
  assign w_lm1 = i_len - LW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_shift) begin
      // History is never flushed on a match, which is what makes
      // overlapping occurrences detectable.
      r_hist <= w_win[PW-2:0];
      if (r_fill < w_lm1)
        r_fill <= r_fill + LW'(1);
    end
  end

  // Only the low L window bits take part in the compare.
  always_comb begin
    w_eq = 1'b1;
    for (int i = 0; i < PW; i++) begin
      if ((i < int'(i_len)) && (w_win[i] != i_pattern[i]))
        w_eq = 1'b0;
    end
  end

  assign o_hit = (r_fill >= w_lm1) & w_eq;

endmodule
`default_nettype wire

// File: rtl/seq_det_prog_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_prog_ctrl
//  Description : Programmable overlapping Mealy sequence detector with a
//                run-control FSM (IDLE / RUN / DONE). Counts matches on a
//                serial stream until a target count or a bit timeout.
//  Ports       : clk, rstn        clock / async active-low reset
//                cfg_we           config write, honoured only in IDLE
//                cfg_pattern      pattern, bit 0 = newest bit
//                cfg_len          pattern length (clamped to 2..PW)
//                cfg_target       matches for done, 0 = free-run
//                cfg_timeout      valid bits allowed in RUN, 0 = disabled
//                start, abort     arm/restart, return to IDLE
//                in, in_valid     serial data and qualifier
//                out              combinational match flag
//                match_cnt        matches since last start (saturating)
//                busy, done       state is RUN / DONE
//                timed_out        DONE was reached by timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_prog_ctrl
  import seq_det_pkg::*;
#(
  parameter int PW = c_DEF_PW,
  parameter int CW = c_DEF_CW,
  parameter int TW = c_DEF_TW
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_we,
  input  logic [PW-1:0]           cfg_pattern,
  input  logic [$clog2(PW+1)-1:0] cfg_len,
  input  logic [CW-1:0]           cfg_target,
  input  logic [TW-1:0]           cfg_timeout,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    in,
  input  logic                    in_valid,
  output logic                    out,
  output logic [CW-1:0]           match_cnt,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out
);

  localparam int LW = $clog2(PW+1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_pattern;
  logic [LW-1:0] r_len;
  logic [CW-1:0] r_target;
  logic [TW-1:0] r_timeout;
  logic [CW-1:0] r_match_cnt;
  logic [TW-1:0] r_bitcnt;
  logic          r_timed_out;

  logic w_go, w_shift, w_hit, w_tgt_hit, w_tmo_hit, w_to_set;

  // abort beats start; a bit arriving with start or abort is discarded.
  assign w_go    = start & ~abort;
  assign w_shift = (r_state == ST_RUN) & in_valid & ~w_go & ~abort;
  assign out     = w_shift & w_hit;

  assign w_tgt_hit = out & (r_target != '0) &
                     ((CW+1)'(r_match_cnt) + (CW+1)'(1) == (CW+1)'(r_target));
  assign w_tmo_hit = w_shift & (r_timeout != '0) &
                     ((TW+1)'(r_bitcnt) + (TW+1)'(1) == (TW+1)'(r_timeout));
  // A match completing the target on the final allowed bit wins.
  assign w_to_set  = w_tmo_hit & ~w_tgt_hit;

  seq_det_match_core #(
    .PW (PW),
    .LW (LW)
  ) u_core (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (w_go),
    .i_shift   (w_shift),
    .i_bit     (in),
    .i_len     (r_len),
    .i_pattern (r_pattern),
    .o_hit     (w_hit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pattern <= '0;
      r_len     <= LW'(2);
      r_target  <= '0;
      r_timeout <= '0;
    end else if (cfg_we && (r_state == ST_IDLE)) begin
      r_pattern <= cfg_pattern;
      r_len     <= LW'(clamp_len(int'(cfg_len), PW));
      r_target  <= cfg_target;
      r_timeout <= cfg_timeout;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (abort)
          w_state_nxt = ST_IDLE;
        else if (w_go)
          w_state_nxt = ST_RUN;
        else if (w_tgt_hit || w_tmo_hit)
          w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (abort)
          w_state_nxt = ST_IDLE;
        else if (w_go)
          w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // match_cnt and timed_out are only touched by start or a counted bit, so
  // they hold through DONE and after abort for host readout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_match_cnt <= '0;
      r_bitcnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (w_go) begin
      r_match_cnt <= '0;
      r_bitcnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (w_shift) begin
      r_bitcnt <= r_bitcnt + TW'(1);
      if (out && (r_match_cnt != '1))
        r_match_cnt <= r_match_cnt + CW'(1);
      if (w_to_set)
        r_timed_out <= 1'b1;
    end
  end

  assign match_cnt = r_match_cnt;
  assign busy      = (r_state == ST_RUN);
  assign done      = (r_state == ST_DONE);
  assign timed_out = r_timed_out;

endmodule
`default_nettype wire
